// File: rtl/uart_rx_frame_chk.sv
// uart_rx_frame_chk: UART receive frame checker.
// Collects one frame (start, 8 data bits LSB first, optional parity, stop)
// from a strobed serial line, then reports it one clock after the stop strobe:
// a DATA_VALID pulse with a new P_DATA, or par_err/stp_err pulses.
// Optional build macro: UART_RX_ERR_CNT_EN adds a saturating 8-bit frame error
// counter on output err_cnt.
module uart_rx_frame_chk (
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_bit,
  input  logic       bit_strb,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic [7:0] P_DATA,
  output logic       DATA_VALID,
  output logic       par_err,
  output logic       stp_err,
  output logic       busy
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ERR_W  = 8;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [1:0]        state, state_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_d;
  logic              par_en_q, par_en_d;
  logic              par_typ_q, par_typ_d;
  logic              par_rx_q, par_rx_d;
  logic [DATA_W-1:0] p_data_d;
  logic              data_valid_d;
  logic              par_err_d;
  logic              stp_err_d;
  logic              busy_d;
  logic              exp_par;

  // Expected parity of the collected byte under the latched encoding.
  assign exp_par = par_typ_q ? (^shift) : ~(^shift);

  // State and datapath registers; reset drops any partial frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_rx_q   <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      shift      <= shift_d;
      bit_cnt    <= bit_cnt_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_rx_q   <= par_rx_d;
      P_DATA     <= p_data_d;
      DATA_VALID <= data_valid_d;
      par_err    <= par_err_d;
      stp_err    <= stp_err_d;
      busy       <= busy_d;
    end
  end

  // Next-state and frame evaluation; every transition is gated by bit_strb.
  always_comb begin
    state_d      = state;
    shift_d      = shift;
    bit_cnt_d    = bit_cnt;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_rx_d     = par_rx_q;
    p_data_d     = P_DATA;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;

    case (state)
      IDLE: begin
        // A 0 on a strobe is a start bit; frame settings are frozen here.
        if (bit_strb && !rx_bit) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          par_rx_d  = 1'b0;
        end
      end
      DATA: begin
        if (bit_strb) begin
          shift_d   = {rx_bit, shift[DATA_W-1:1]};
          bit_cnt_d = bit_cnt + CNT_W'(1);
          if (bit_cnt == LAST_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_strb) begin
          par_rx_d = rx_bit;
          state_d  = STOP;
        end
      end
      STOP: begin
        if (bit_strb) begin
          state_d      = IDLE;
          par_err_d    = par_en_q && (par_rx_q != exp_par);
          stp_err_d    = !rx_bit;
          data_valid_d = !par_err_d && !stp_err_d;
          if (data_valid_d) begin
            p_data_d = shift;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [ERR_W-1:0] err_cnt_d;

  // Count errored frames, holding at the maximum value.
  always_comb begin
    err_cnt_d = err_cnt;
    if ((par_err_d || stp_err_d) && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt + ERR_W'(1);
    end
  end

  // Error counter register; only reset clears it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_frame_chk.sv
// Testbench for uart_rx_frame_chk: directed and randomized frames checked
// against a frame-level reference model. Honors UART_RX_ERR_CNT_EN.
module tb_uart_rx_frame_chk;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       rx_bit = 1'b1;
  logic       bit_strb = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       par_err;
  logic       stp_err;
  logic       busy;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_pdata = 8'h00;
  int exp_err_cnt = 0;

  uart_rx_frame_chk dut (
    .CLK       (CLK),
    .RST       (RST),
    .rx_bit    (rx_bit),
    .bit_strb  (bit_strb),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .par_err   (par_err),
    .stp_err   (stp_err),
    .busy      (busy)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // One strobed bit, preceded by up to maxgap idle cycles of line noise.
  task automatic strobe(input logic b, input int maxgap);
    int unsigned gap;
    gap = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
    for (int i = 0; i < int'(gap); i++) begin
      bit_strb = 1'b0;
      rx_bit   = 1'($urandom);
      @(posedge CLK); #1;
    end
    bit_strb = 1'b1;
    rx_bit   = b;
    @(posedge CLK); #1;
    bit_strb = 1'b0;
    rx_bit   = 1'($urandom);
  endtask

  // Full frame plus reference-model check of the result cycle.
  task automatic send_frame(input logic [7:0] data, input logic pe, input logic pt,
                            input logic pbit, input logic sbit, input int maxgap,
                            input bit scramble, input bit b2b, input string tag);
    bit par_ok, e_pe, e_se, e_dv;
    PAR_EN  = pe;
    PAR_TYP = pt;
    strobe(1'b0, maxgap);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_after_start got=%b want=1", tag, busy);
    end
    if (scramble) begin
      PAR_EN  = ~pe;
      PAR_TYP = ~pt;
    end
    for (int i = 0; i < 8; i++) begin
      strobe(data[i], maxgap);
      if (scramble) begin
        PAR_EN  = 1'($urandom);
        PAR_TYP = 1'($urandom);
      end
    end
    checks++;
    if ({DATA_VALID, par_err, stp_err} !== 3'b000) begin
      failures++;
      $display("FAIL %s early_pulse got=%b want=000", tag, {DATA_VALID, par_err, stp_err});
    end
    if (pe) strobe(pbit, maxgap);
    strobe(sbit, maxgap);

    // Even parity (PAR_TYP=1) makes data+parity ones even; odd otherwise.
    par_ok = (($countones(data) + int'(pbit)) % 2) == (pt ? 0 : 1);
    e_pe   = pe && !par_ok;
    e_se   = (sbit == 1'b0);
    e_dv   = !e_pe && !e_se;
    if (e_dv) exp_pdata = data;
    if ((e_pe || e_se) && exp_err_cnt < 255) exp_err_cnt++;

    checks++;
    if (DATA_VALID !== e_dv) begin
      failures++;
      $display("FAIL %s data_valid got=%b want=%b", tag, DATA_VALID, e_dv);
    end
    checks++;
    if (par_err !== e_pe) begin
      failures++;
      $display("FAIL %s par_err got=%b want=%b", tag, par_err, e_pe);
    end
    checks++;
    if (stp_err !== e_se) begin
      failures++;
      $display("FAIL %s stp_err got=%b want=%b", tag, stp_err, e_se);
    end
    checks++;
    if (P_DATA !== exp_pdata) begin
      failures++;
      $display("FAIL %s p_data got=%h want=%h", tag, P_DATA, exp_pdata);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_stop got=%b want=0", tag, busy);
    end
`ifdef UART_RX_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'(exp_err_cnt)) begin
      failures++;
      $display("FAIL %s err_cnt got=%0d want=%0d", tag, err_cnt, exp_err_cnt);
    end
`endif
    if (!b2b) begin
      @(posedge CLK); #1;
      checks++;
      if ({DATA_VALID, par_err, stp_err, busy} !== 4'b0000) begin
        failures++;
        $display("FAIL %s pulse_width got=%b want=0000", tag, {DATA_VALID, par_err, stp_err, busy});
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    checks++;
    if ({P_DATA, DATA_VALID, par_err, stp_err, busy} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state got=%h want=000", {P_DATA, DATA_VALID, par_err, stp_err, busy});
    end
`ifdef UART_RX_ERR_CNT_EN
    checks++;
    if (err_cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_err_cnt got=%h want=00", err_cnt);
    end
`endif
  endtask

  task automatic test_directed();
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0, "good_a5");
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0, "par_err_01");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "stp_err_3c");
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "good_3c");
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, "both_err");
  endtask

  task automatic test_idle_ones();
    for (int i = 0; i < 5; i++) strobe(1'b1, 2);
    checks++;
    if ({DATA_VALID, par_err, stp_err, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL idle_ones got=%b want=0000", {DATA_VALID, par_err, stp_err, busy});
    end
  endtask

  task automatic test_reset_mid_frame();
    PAR_EN = 1'b0;
    strobe(1'b0, 0);
    for (int i = 0; i < 4; i++) strobe(1'($urandom), 1);
    RST = 1'b0;
    #1;
    exp_pdata   = 8'h00;
    exp_err_cnt = 0;
    checks++;
    if ({P_DATA, DATA_VALID, par_err, stp_err, busy} !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset got=%h want=000", {P_DATA, DATA_VALID, par_err, stp_err, busy});
    end
    @(negedge CLK) RST = 1'b1;
    @(posedge CLK); #1;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "after_reset_5a");
  endtask

  task automatic test_back_to_back();
    send_frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1, "b2b_11");
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b1, 1'b0, "b2b_22");
  endtask

  task automatic test_break();
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, "break_1");
    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "break_2");
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "after_break");
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic pe, pt, pb, sb;
    for (int n = 0; n < 60; n++) begin
      d  = 8'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      pb = 1'((($countones(d) % 2) == 1) == pt ? 1'b0 : 1'b1);
      if ($urandom_range(3, 0) == 0) pb = ~pb;
      sb = ($urandom_range(4, 0) != 0);
      send_frame(d, pe, pt, pb, sb, 3, 1'b1, 1'($urandom), "random");
    end
  endtask

`ifdef UART_RX_ERR_CNT_EN
  task automatic test_err_cnt();
    for (int n = 0; n < 300; n++) begin
      send_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, "cnt_err");
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL err_cnt_sat got=%h want=ff", err_cnt);
    end
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, "cnt_good");
    checks++;
    if (err_cnt !== 8'hFF) begin
      failures++;
      $display("FAIL err_cnt_hold got=%h want=ff", err_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_idle_ones();
    test_reset_mid_frame();
    test_back_to_back();
    test_break();
    test_random();
`ifdef UART_RX_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_chk.md
UART_RX_FRAME_CHK -- requirements
Module: uart_rx_frame_chk

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock, rising edge; all state changes on this edge.
REQ-002 SHALL have: RST  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: rx_bit  in  1  sampled serial line value, meaningful only when bit_strb=1.
REQ-004 SHALL have: bit_strb  in  1  one-cycle pulse, one per received bit period (mid-bit sample ready).
REQ-005 SHALL have: PAR_EN  in  1  1 = frame carries a parity bit.
REQ-006 SHALL have: PAR_TYP  in  1  parity encoding select (see REQ-013).
REQ-007 SHALL have: P_DATA  out  8  last error-free received byte.
REQ-008 SHALL have: DATA_VALID  out  1  one-cycle pulse; P_DATA updated this cycle.
REQ-009 SHALL have: par_err, stp_err  out  1 each  one-cycle frame-error pulses.
REQ-010 SHALL have: busy  out  1  high while a frame is in progress (state != IDLE).

Function
REQ-011 SHALL implement FSM states IDLE, DATA, PARITY, STOP; all transitions occur only on cycles with bit_strb=1.
- IDLE: bit_strb with rx_bit=0 accepts start bit -> DATA; rx_bit=1 ignored, stay IDLE.
- DATA: shift rx_bit in LSB first; after the 8th strobe -> PARITY if latched PAR_EN=1, else STOP.
- PARITY: capture rx_bit as received parity -> STOP.
- STOP: capture rx_bit as stop bit -> IDLE.
REQ-012 SHALL latch PAR_EN and PAR_TYP on start-bit acceptance; changes mid-frame have no effect on the current frame.
REQ-013 SHALL compute expected parity bit = XOR of the 8 data bits when PAR_TYP=1, inverted XOR when PAR_TYP=0.
REQ-014 SHALL evaluate the frame in the cycle after the stop strobe (latency 1 clock). par_err=1 if parity is enabled and mismatches. stp_err=1 if the stop bit is 0. DATA_VALID=1 only if neither error is present.
REQ-015 SHALL load P_DATA only in the DATA_VALID cycle; an errored frame leaves P_DATA unchanged.
REQ-016 par_err and stp_err SHALL both pulse in the same cycle when both errors occur.
REQ-017 SHALL accept a new start strobe in the cycle immediately after the stop strobe (back-to-back frames); the result pulses of the previous frame are still emitted.
REQ-018 SHALL ignore the line value between strobes. Strobes on consecutive clock cycles SHALL be legal.
REQ-019 An all-zero line (break) SHALL complete a frame with stp_err=1 and then restart on the next 0 strobe.
REQ-020 busy SHALL rise in the cycle after start-bit acceptance and fall in the cycle after the stop strobe.

Reset
REQ-021 On RST=0, SHALL asynchronously enter IDLE and clear: P_DATA=0x00, DATA_VALID=0, par_err=0, stp_err=0, busy=0, shift register and bit counter.
REQ-022 Reset mid-frame SHALL discard the partial frame with no result pulse. The first strobe after release SHALL be treated as a possible start bit.

Configuration
REQ-023 With macro UART_RX_ERR_CNT_EN defined, SHALL add output err_cnt [7:0]: increments once per frame with par_err or stp_err, saturates at 0xFF, cleared only by RST.
REQ-024 Without UART_RX_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-025 PAR_EN=1, PAR_TYP=0, start 0, data 0xA5, parity 1, stop 1 -> DATA_VALID pulse 1 clock after stop strobe, P_DATA=0xA5, no error pulses.
REQ-026 PAR_EN=1, PAR_TYP=1, data 0x01, parity 0, stop 1 -> par_err pulse, no DATA_VALID, P_DATA keeps prior value 0xA5.
REQ-027 PAR_EN=0, data 0x3C, stop 0 -> stp_err pulse after the 10th strobe, no DATA_VALID; then a frame with 0x3C and stop 1 -> DATA_VALID, P_DATA=0x3C.
REQ-028 Assert RST after 4 data strobes -> busy=0 and all outputs 0 immediately. Next full frame 0x5A (PAR_EN=0) -> DATA_VALID, P_DATA=0x5A.
REQ-029 Two back-to-back frames 0x11, 0x22 with strobes every clock and PAR_EN toggled mid-frame -> two DATA_VALID pulses, values 0x11 then 0x22, parity per the latched setting.
REQ-030 With UART_RX_ERR_CNT_EN: 300 frames with stop 0 -> err_cnt=0xFF; a good frame afterwards leaves err_cnt at 0xFF.
